inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, is the instruction-memory capacity in 32-bit words.
REQ-002 Parameter LEN_W, default 7, is the width of the load-length input; it SHALL satisfy 2^LEN_W > DEPTH_WORDS.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: one-cycle request to begin a program load.
REQ-006 Port len, input, LEN_W bits: number of words to load, sampled only with an accepted start.
REQ-007 Port byte_in, input, 8 bits: serial program byte.
REQ-008 Port byte_valid, input, 1 bit: byte_in is valid this cycle.
REQ-009 Port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-010 Port wr_en, output, 1 bit: instruction-memory write strobe.
REQ-011 Port wr_addr, output, 32 bits: byte address of the word being written.
REQ-012 Port wr_data, output, 32 bits: instruction word being written.
REQ-013 Port busy, output, 1 bit: a load is in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse at load completion.
REQ-015 Port cpu_hold, output, 1 bit: holds the processor in reset while memory is being rewritten.

Function
REQ-016 The FSM SHALL have four states: IDLE, RECV, WRITE, DONE.
REQ-017 In IDLE, an asserted start SHALL latch len, clamped to DEPTH_WORDS if larger, clear the word index and byte counter, and move to RECV; if the latched length is 0, it SHALL move to DONE instead.
REQ-018 A start asserted in any state other than IDLE SHALL be ignored.
REQ-019 byte_ready SHALL be 1 only in RECV.
REQ-020 A byte SHALL be accepted only when byte_valid && byte_ready; byte_valid in any other state SHALL be ignored, and the source must hold the byte.
REQ-021 Bytes SHALL be assembled big-endian: the first accepted byte goes to bits 31:24 and the fourth to bits 7:0.
REQ-022 On acceptance of the fourth byte of a word, the FSM SHALL move to WRITE on the next edge.
REQ-023 WRITE SHALL last exactly one cycle, with wr_en=1, wr_data = the assembled word, and wr_addr = word_index*4.
REQ-024 wr_en SHALL be 0 in every state other than WRITE.
REQ-025 After WRITE, the word index SHALL increment; if the index just written equals latched length-1, the FSM SHALL go to DONE, otherwise it SHALL return to RECV with the byte counter at 0.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-027 Latency: a fourth byte accepted at cycle N SHALL produce wr_en at N+1; for the final word, done SHALL follow at N+2.
REQ-028 busy and cpu_hold SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-029 wr_addr SHALL never exceed (DEPTH_WORDS-1)*4.
REQ-030 When byte_valid is held continuously, the loader SHALL accept 4 bytes per 5 cycles.

Reset
REQ-031 While reset=1 at a clock edge, the loader SHALL enter IDLE with word index 0, byte counter 0 and assembly register 0.
REQ-032 During and after reset, the outputs SHALL be byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0 and cpu_hold=0.
REQ-033 A reset asserted mid-load SHALL discard any partial word without issuing a write, and SHALL NOT pulse done.
REQ-034 Reset SHALL take priority over start and byte_valid in the same cycle.

Verification
REQ-035 Bench: start with len=2, stream 8C 09 00 00 20 0A 00 05 with valid held -> wr_en at addr 0 with data 0x8C090000, then at addr 4 with data 0x200A0005, done one cycle after the second write, 10 cycles total from the first accepted byte.
REQ-036 Bench: len=1 with byte_valid toggled 1,0,1,0,... -> exactly 4 bytes accepted, one write, byte_ready low during WRITE, no byte lost or duplicated.
REQ-037 Bench: len=0 -> done pulses on the cycle after the start cycle, with no wr_en.
REQ-038 Bench: len=100 with DEPTH_WORDS=64 -> exactly 64 writes, last at wr_addr 252, then done.
REQ-039 Bench: reset after 2 bytes of word 1, then start len=1 with bytes 00 00 00 0C -> no write before reset, single write of addr 0 data 0x0000000C.
REQ-040 Bench: start pulsed while busy -> ignored, and the original load completes unchanged.

Source files
------------

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//   Receives a program as a stream of bytes, packs each group of four bytes
//   into a big-endian 32-bit instruction word and writes it into the
//   instruction memory at consecutive word addresses. The processor is held
//   in reset for the whole load.
//
// Parameters
//   DEPTH_WORDS : instruction-memory capacity in 32-bit words
//   LEN_W       : width of len; 2**LEN_W must exceed DEPTH_WORDS
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   one-cycle request to begin a load (IDLE only)
//   len        in   number of words to load, sampled with an accepted start
//   byte_in    in   serial program byte
//   byte_valid in   byte_in is valid; source holds it until accepted
//   byte_ready out  loader accepts a byte this cycle
//   wr_en      out  instruction-memory write strobe
//   wr_addr    out  byte address of the word being written
//   wr_data    out  instruction word being written
//   busy       out  a load is in progress
//   done       out  one-cycle pulse at load completion
//   cpu_hold   out  keeps the processor in reset during the load
// -----------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int LEN_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             cpu_hold
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_WORDS);

  state_t           state_q,  state_d;
  logic [LEN_W-1:0] len_q,    len_d;
  logic [LEN_W-1:0] idx_q,    idx_d;
  logic [1:0]       bcnt_q,   bcnt_d;
  logic [31:0]      asm_q,    asm_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Lengths beyond the memory size are clamped so the address
          // never runs past the last word.
          len_d   = (len > DEPTH_L) ? DEPTH_L : len;
          idx_d   = '0;
          bcnt_d  = '0;
          asm_d   = '0;
          state_d = (len == '0) ? DONE : RECV;
        end
      end

      RECV: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          // Shift left so the first byte ends up in bits 31:24.
          asm_d  = {asm_q[23:0], byte_in};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {{(30-LEN_W){1'b0}}, idx_q, 2'b00};
        wr_data = asm_q;
        idx_d   = idx_q + LEN_W'(1);
        bcnt_d  = '0;
        state_d = (idx_q == len_q - LEN_W'(1)) ? DONE : RECV;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign cpu_hold = (state_q != IDLE);

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam int DEPTH_WORDS = 64;
  localparam int LEN_W       = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             cpu_hold;

  int errors = 0;
  int checks = 0;

  inst_mem_loader #(.DEPTH_WORDS(DEPTH_WORDS), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  // Cycle counter and event logs, captured on the falling edge.
  int          cyc = 0;
  int          wr_cnt = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] max_addr = '0;
  logic [31:0] wr_addr_log [0:127];
  logic [31:0] wr_data_log [0:127];
  int          wr_cyc_log  [0:127];
  logic        wr_rdy_log  [0:127];
  logic [7:0]  acc_data_log[0:511];
  int          acc_cyc_log [0:511];
  int          done_cyc_log[0:15];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 128) begin
        wr_addr_log[wr_cnt] = wr_addr;
        wr_data_log[wr_cnt] = wr_data;
        wr_cyc_log[wr_cnt]  = cyc;
        wr_rdy_log[wr_cnt]  = byte_ready;
      end
      if (wr_addr > max_addr) max_addr = wr_addr;
      wr_cnt = wr_cnt + 1;
    end
    if (byte_valid && byte_ready && !reset) begin
      if (acc_cnt < 512) begin
        acc_data_log[acc_cnt] = byte_in;
        acc_cyc_log[acc_cnt]  = cyc;
      end
      acc_cnt = acc_cnt + 1;
    end
    if (done) begin
      if (done_cnt < 16) done_cyc_log[done_cnt] = cyc;
      done_cnt = done_cnt + 1;
    end
  end

  logic [7:0] src [0:255];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Feeds src[0..n-1] honouring byte_ready until done is seen.
  task automatic stream(input int n, input bit toggle, input int ga, input int gb,
                        input logic [LEN_W-1:0] glen, input int budget);
    int  i;
    int  step;
    int  d0;
    logic rdy;
    i = 0;
    step = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && step < budget) begin
      rdy        = byte_ready;
      byte_valid = (i < n) && (!toggle || (step % 2 == 0));
      byte_in    = src[i % 256];
      start      = (step == ga) || (step == gb);
      if (start) len = glen;
      tick();
      if (byte_valid && rdy) i++;
      start = 1'b0;
      step++;
    end
    byte_valid = 1'b0;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL stream_timeout: done not seen after %0d cycles, required within %0d", step, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; len = 7'd3; byte_valid = 1'b1; byte_in = 8'hFF;
    tick(); tick();
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b need 0", byte_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b need 0", wr_en); end
    checks++; if (wr_addr !== 32'h0) begin errors++; $display("FAIL reset_wr_addr: got %h need 0", wr_addr); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h need 0", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold: got %b need 0", cpu_hold); end
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL after_reset_busy: got %b need 0", busy); end
  endtask

  task automatic test_len2();
    int wb, ab, db;
    wb = wr_cnt; ab = acc_cnt; db = done_cnt;
    src[0] = 8'h8C; src[1] = 8'h09; src[2] = 8'h00; src[3] = 8'h00;
    src[4] = 8'h20; src[5] = 8'h0A; src[6] = 8'h00; src[7] = 8'h05;
    do_start(7'd2);
    checks++; if (busy !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
      errors++; $display("FAIL len2_recv_flags: busy=%b hold=%b rdy=%b need 1 1 1", busy, cpu_hold, byte_ready); end
    stream(8, 1'b0, -1, -1, 7'd2, 40);
    checks++; if (wr_cnt - wb !== 2) begin errors++; $display("FAIL len2_writes: got %0d need 2", wr_cnt - wb); end
    checks++; if (wr_addr_log[wb] !== 32'h0 || wr_data_log[wb] !== 32'h8C090000) begin
      errors++; $display("FAIL len2_word0: addr %h data %h need 0 8c090000", wr_addr_log[wb], wr_data_log[wb]); end
    checks++; if (wr_addr_log[wb+1] !== 32'h4 || wr_data_log[wb+1] !== 32'h200A0005) begin
      errors++; $display("FAIL len2_word1: addr %h data %h need 4 200a0005", wr_addr_log[wb+1], wr_data_log[wb+1]); end
    checks++; if (wr_cyc_log[wb] - acc_cyc_log[ab+3] !== 1) begin
      errors++; $display("FAIL len2_wr_latency: got %0d need 1", wr_cyc_log[wb] - acc_cyc_log[ab+3]); end
    checks++; if (done_cyc_log[db] - wr_cyc_log[wb+1] !== 1) begin
      errors++; $display("FAIL len2_done_latency: got %0d need 1", done_cyc_log[db] - wr_cyc_log[wb+1]); end
    checks++; if (done_cyc_log[db] - acc_cyc_log[ab] !== 10) begin
      errors++; $display("FAIL len2_total_cycles: got %0d need 10", done_cyc_log[db] - acc_cyc_log[ab]); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || done_cnt - db !== 1) begin
      errors++; $display("FAIL len2_idle_after: busy=%b done=%b pulses=%0d need 0 0 1", busy, done, done_cnt - db); end
  endtask

  task automatic test_toggle();
    int wb, ab;
    wb = wr_cnt; ab = acc_cnt;
    src[0] = 8'hDE; src[1] = 8'hAD; src[2] = 8'hBE; src[3] = 8'hEF;
    do_start(7'd1);
    stream(4, 1'b1, -1, -1, 7'd1, 40);
    checks++; if (acc_cnt - ab !== 4) begin errors++; $display("FAIL toggle_bytes: got %0d need 4", acc_cnt - ab); end
    checks++; if ({acc_data_log[ab], acc_data_log[ab+1], acc_data_log[ab+2], acc_data_log[ab+3]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL toggle_byte_order: got %h%h%h%h need deadbeef",
        acc_data_log[ab], acc_data_log[ab+1], acc_data_log[ab+2], acc_data_log[ab+3]); end
    checks++; if (wr_cnt - wb !== 1) begin errors++; $display("FAIL toggle_writes: got %0d need 1", wr_cnt - wb); end
    checks++; if (wr_data_log[wb] !== 32'hDEADBEEF || wr_addr_log[wb] !== 32'h0) begin
      errors++; $display("FAIL toggle_word: addr %h data %h need 0 deadbeef", wr_addr_log[wb], wr_data_log[wb]); end
    checks++; if (wr_rdy_log[wb] !== 1'b0) begin errors++; $display("FAIL toggle_ready_in_write: got %b need 0", wr_rdy_log[wb]); end
    tick();
  endtask

  task automatic test_len0();
    int wb, db;
    wb = wr_cnt; db = done_cnt;
    do_start(7'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b0) begin
      errors++; $display("FAIL len0_done: done=%b busy=%b rdy=%b need 1 1 0", done, busy, byte_ready); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL len0_after: done=%b busy=%b need 0 0", done, busy); end
    checks++; if (wr_cnt - wb !== 0 || done_cnt - db !== 1) begin
      errors++; $display("FAIL len0_counts: writes=%0d dones=%0d need 0 1", wr_cnt - wb, done_cnt - db); end
  endtask

  task automatic test_clamp();
    int wb, db;
    wb = wr_cnt; db = done_cnt;
    max_addr = '0;
    for (int k = 0; k < 256; k++) src[k] = k[7:0];
    do_start(7'd100);
    stream(256, 1'b0, -1, -1, 7'd100, 400);
    checks++; if (wr_cnt - wb !== 64) begin errors++; $display("FAIL clamp_writes: got %0d need 64", wr_cnt - wb); end
    checks++; if (wr_addr_log[wb+63] !== 32'd252 || wr_data_log[wb+63] !== 32'hFCFDFEFF) begin
      errors++; $display("FAIL clamp_last: addr %0d data %h need 252 fcfdfeff", wr_addr_log[wb+63], wr_data_log[wb+63]); end
    checks++; if (wr_data_log[wb+1] !== 32'h04050607 || wr_addr_log[wb+1] !== 32'd4) begin
      errors++; $display("FAIL clamp_word1: addr %0d data %h need 4 04050607", wr_addr_log[wb+1], wr_data_log[wb+1]); end
    checks++; if (max_addr > 32'd252) begin errors++; $display("FAIL clamp_max_addr: got %0d need <= 252", max_addr); end
    checks++; if (done_cyc_log[db] - wr_cyc_log[wb+63] !== 1) begin
      errors++; $display("FAIL clamp_done: got %0d need 1", done_cyc_log[db] - wr_cyc_log[wb+63]); end
    tick();
  endtask

  task automatic test_reset_mid();
    int wb, db;
    wb = wr_cnt; db = done_cnt;
    do_start(7'd2);
    byte_valid = 1'b1; byte_in = 8'hAA; tick();
    byte_in = 8'hBB; tick();
    reset = 1'b1; start = 1'b1; len = 7'd1; byte_in = 8'hCC; tick();
    checks++; if (busy !== 1'b0 || byte_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: busy=%b rdy=%b wr=%b done=%b need 0 0 0 0", busy, byte_ready, wr_en, done); end
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (wr_cnt - wb !== 0 || done_cnt - db !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_discard: writes=%0d dones=%0d busy=%b need 0 0 0", wr_cnt - wb, done_cnt - db, busy); end
    src[0] = 8'h00; src[1] = 8'h00; src[2] = 8'h00; src[3] = 8'h0C;
    do_start(7'd1);
    stream(4, 1'b0, -1, -1, 7'd1, 40);
    checks++; if (wr_cnt - wb !== 1 || wr_addr_log[wb] !== 32'h0 || wr_data_log[wb] !== 32'h0000000C) begin
      errors++; $display("FAIL midreset_reload: writes=%0d addr %h data %h need 1 0 0000000c",
        wr_cnt - wb, wr_addr_log[wb], wr_data_log[wb]); end
    tick();
  endtask

  task automatic test_start_busy();
    int wb, db;
    wb = wr_cnt; db = done_cnt;
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    src[4] = 8'h55; src[5] = 8'h66; src[6] = 8'h77; src[7] = 8'h88;
    do_start(7'd2);
    // Step 2 lands in RECV, step 4 in WRITE.
    stream(8, 1'b0, 2, 4, 7'd5, 40);
    checks++; if (wr_cnt - wb !== 2) begin errors++; $display("FAIL busy_start_writes: got %0d need 2", wr_cnt - wb); end
    checks++; if (wr_data_log[wb] !== 32'h11223344 || wr_data_log[wb+1] !== 32'h55667788 || wr_addr_log[wb+1] !== 32'h4) begin
      errors++; $display("FAIL busy_start_words: %h %h addr1 %h need 11223344 55667788 4",
        wr_data_log[wb], wr_data_log[wb+1], wr_addr_log[wb+1]); end
    tick(); tick();
    checks++; if (busy !== 1'b0 || done_cnt - db !== 1) begin
      errors++; $display("FAIL busy_start_end: busy=%b dones=%0d need 0 1", busy, done_cnt - db); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; len = '0; byte_in = '0; byte_valid = 1'b0;
    test_reset();
    test_len2();
    test_toggle();
    test_len0();
    test_clamp();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
